aes_key_word_loader: RTL and testbench

- Upstream sequencer for the cipher unit's 1-to-8 write-enable demultiplexer.
- Accepts cipher key words over a valid/ready stream and produces one registered write strobe per word, plus a 3-bit word-slot select and the word data.
- The strobe drives the demux data input, which fans it out to eight 32-bit key-word registers.
- Supports AES-128, AES-192 and AES-256 key lengths (4, 6 or 8 words).

---
 rtl/aes_key_word_loader_if.sv | 36 +++
 rtl/aes_key_word_loader.sv | 154 +++++++++++++++
 tb/tb_aes_key_word_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_word_loader_if.sv
`default_nettype none
// ============================================================================
// aes_key_word_loader_if : key-word input stream plus demux write bus
// Rev 1.0
// ============================================================================
interface aes_key_word_loader_if #(
    parameter int WORD_W     = 32,
    parameter int NSLOT_LOG2 = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     in_word;
    logic                  wr_en;
    logic [NSLOT_LOG2-1:0] wr_sel;
    logic [WORD_W-1:0]     wr_word;

    // master = key source / demux side, slave = the loader
    modport master (
        output in_valid,
        output in_word,
        input  in_ready,
        input  wr_en,
        input  wr_sel,
        input  wr_word
    );

    modport slave (
        input  in_valid,
        input  in_word,
        output in_ready,
        output wr_en,
        output wr_sel,
        output wr_word
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_word_loader.sv
`default_nettype none
// ============================================================================
// aes_key_word_loader : sequences 4/6/8 AES key words into an 8-slot demux.
// Optional AES_KEY_LOADER_BSWAP_EN byte-reverses each word before the write.
// Rev 1.0
// ============================================================================
module aes_key_word_loader #(
    parameter int WORD_W     = 32,
    parameter int NSLOT_LOG2 = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [1:0]                  key_len_i,
    aes_key_word_loader_if.slave        bus,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int         c_CNT_W        = NSLOT_LOG2 + 1;
    localparam logic [1:0] c_KEYLEN_128   = 2'b00;
    localparam logic [1:0] c_KEYLEN_192   = 2'b01;
    localparam logic [1:0] c_KEYLEN_256   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NSLOT_LOG2-1:0]  count_q, count_d;
    logic [c_CNT_W-1:0]     nwords_q, nwords_d;
    logic                   wr_en_q, wr_en_d;
    logic [NSLOT_LOG2-1:0]  wr_sel_q, wr_sel_d;
    logic [WORD_W-1:0]      wr_word_q, wr_word_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   w_xfer;
    logic                   w_last;
    logic                   w_len_rsvd;
    logic [c_CNT_W-1:0]     w_nwords_dec;
    logic [WORD_W-1:0]      w_word_fmt;

`ifdef AES_KEY_LOADER_BSWAP_EN
    localparam int c_NBYTES = WORD_W / 8;
    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_bswap
        assign w_word_fmt[8*gi +: 8] = bus.in_word[WORD_W-8-8*gi +: 8];
    end
`else
    assign w_word_fmt = bus.in_word;
`endif

    // in_ready depends on state only, so no in_valid -> in_ready path exists
    assign bus.in_ready = (state_q == S_LOAD);
    assign w_xfer       = bus.in_valid && bus.in_ready;
    assign w_last       = ({1'b0, count_q} == (nwords_q - 1'b1));

    always_comb begin
        w_len_rsvd   = 1'b0;
        w_nwords_dec = '0;
        case (key_len_i)
            c_KEYLEN_128: w_nwords_dec = c_CNT_W'(4);
            c_KEYLEN_192: w_nwords_dec = c_CNT_W'(6);
            c_KEYLEN_256: w_nwords_dec = c_CNT_W'(8);
            default:      w_len_rsvd   = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        nwords_d  = nwords_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_word_d = wr_word_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (w_len_rsvd) begin
                        err_d = 1'b1;
                    end else begin
                        nwords_d = w_nwords_dec;
                        count_d  = '0;
                        busy_d   = 1'b1;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = count_q;
                    wr_word_d = w_word_fmt;
                    if (w_last) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            nwords_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_word_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            nwords_q  <= nwords_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_word_q <= wr_word_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_word = wr_word_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_word_loader.sv
`default_nettype none
// ============================================================================
// tb_aes_key_word_loader : directed self-checking bench for the key loader
// Rev 1.0
// ============================================================================
module tb_aes_key_word_loader;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        start_i   = 1'b0;
    logic [1:0]  key_len_i = 2'b00;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  ctl;
    int          checks = 0;
    int          errors = 0;

    aes_key_word_loader_if #(.WORD_W(32), .NSLOT_LOG2(3)) bus ();

    aes_key_word_loader #(.WORD_W(32), .NSLOT_LOG2(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .key_len_i (key_len_i),
        .bus       (bus),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    // {in_ready, wr_en, wr_sel[2:0], busy, done, err}
    assign ctl = {bus.in_ready, bus.wr_en, bus.wr_sel, busy_o, done_o, err_o};

    function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef AES_KEY_LOADER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if (ctl !== 8'h00 || bus.wr_word !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b word=%h expected ctl=00000000 word=00000000", ctl, bus.wr_word);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (ctl !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 00000000", ctl);
        end
    endtask

    task automatic test_aes128;
        logic [31:0] k [4];
        logic [7:0]  exp;
        k = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
        start_i = 1'b1; key_len_i = 2'b00;
        tick;
        start_i = 1'b0;
        checks++;
        if (ctl !== 8'b1_0_000_100) begin
            errors++;
            $display("FAIL aes128_start: got %b expected 10000100", ctl);
        end
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_word = k[i];
            tick;
            exp = {i != 3, 1'b1, 3'(i), 1'b1, 2'b00};
            checks++;
            if (ctl !== exp || bus.wr_word !== fmt(k[i])) begin
                errors++;
                $display("FAIL aes128_word%0d: got ctl=%b word=%h expected ctl=%b word=%h", i, ctl, bus.wr_word, exp, fmt(k[i]));
            end
        end
        bus.in_word = 32'hDEADBEEF;
        tick;
        checks++;
        if (ctl !== 8'b0_0_011_010) begin
            errors++;
            $display("FAIL aes128_done: got %b expected 00011010", ctl);
        end
        bus.in_valid = 1'b0;
        tick;
        checks++;
        if (ctl !== 8'b0_0_011_000 || bus.wr_word !== fmt(k[3])) begin
            errors++;
            $display("FAIL aes128_after: got ctl=%b word=%h expected ctl=00011000 word=%h", ctl, bus.wr_word, fmt(k[3]));
        end
    endtask

    task automatic test_aes256_gaps;
        logic [7:0]  exp;
        logic [31:0] w;
        int          strobes;
        strobes = 0;
        start_i = 1'b1; key_len_i = 2'b10;
        tick;
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = 32'hA5000000 | 32'(i);
            bus.in_valid = 1'b1; bus.in_word = w;
            tick;
            if (bus.wr_en) strobes++;
            exp = {i != 7, 1'b1, 3'(i), 1'b1, 2'b00};
            checks++;
            if (ctl !== exp || bus.wr_word !== fmt(w)) begin
                errors++;
                $display("FAIL aes256_word%0d: got ctl=%b word=%h expected ctl=%b word=%h", i, ctl, bus.wr_word, exp, fmt(w));
            end
            bus.in_valid = 1'b0; bus.in_word = 32'hFFFFFFFF;
            tick;
            if (bus.wr_en) strobes++;
            exp = {i != 7, 1'b0, 3'(i), i != 7, i == 7, 1'b0};
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL aes256_gap%0d: got %b expected %b", i, ctl, exp);
            end
        end
        tick;
        checks++;
        if (strobes !== 8 || ctl !== 8'b0_0_111_000) begin
            errors++;
            $display("FAIL aes256_strobes: got %0d strobes ctl=%b expected 8 strobes ctl=00111000", strobes, ctl);
        end
    endtask

    task automatic test_reserved;
        start_i = 1'b1; key_len_i = 2'b11; bus.in_valid = 1'b1;
        tick;
        start_i = 1'b0;
        checks++;
        if (ctl !== 8'b0_0_111_001) begin
            errors++;
            $display("FAIL reserved_err: got %b expected 00111001", ctl);
        end
        tick;
        checks++;
        if (ctl !== 8'b0_0_111_000) begin
            errors++;
            $display("FAIL reserved_after: got %b expected 00111000", ctl);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_midload;
        logic [7:0]  exp;
        logic [31:0] w;
        start_i = 1'b1; key_len_i = 2'b01;
        tick;
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                start_i = 1'b1; key_len_i = 2'b00;
            end
            w = 32'h19200000 | 32'(i);
            bus.in_valid = 1'b1; bus.in_word = w;
            tick;
            start_i = 1'b0;
            exp = {i != 5, 1'b1, 3'(i), 1'b1, 2'b00};
            checks++;
            if (ctl !== exp || bus.wr_word !== fmt(w)) begin
                errors++;
                $display("FAIL aes192_word%0d: got ctl=%b word=%h expected ctl=%b word=%h", i, ctl, bus.wr_word, exp, fmt(w));
            end
        end
        bus.in_valid = 1'b0;
        tick;
        checks++;
        if (ctl !== 8'b0_0_101_010) begin
            errors++;
            $display("FAIL aes192_done: got %b expected 00101010", ctl);
        end
        tick;
        checks++;
        if (ctl !== 8'b0_0_101_000) begin
            errors++;
            $display("FAIL aes192_no_requeue: got %b expected 00101000", ctl);
        end

        start_i = 1'b1; key_len_i = 2'b10;
        tick;
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_word = 32'h0BAD0000 | 32'(i);
            tick;
        end
        checks++;
        if (ctl !== 8'b1_1_011_100) begin
            errors++;
            $display("FAIL abort_pre: got %b expected 11011100", ctl);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 8'h00 || bus.wr_word !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: got ctl=%b word=%h expected ctl=00000000 word=00000000", ctl, bus.wr_word);
        end
        bus.in_valid = 1'b0;
        tick;
        rst = 1'b0;
        start_i = 1'b1; key_len_i = 2'b00;
        tick;
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 32'hC0FFEE00 | 32'(i);
            bus.in_valid = 1'b1; bus.in_word = w;
            tick;
            exp = {i != 3, 1'b1, 3'(i), 1'b1, 2'b00};
            checks++;
            if (ctl !== exp || bus.wr_word !== fmt(w)) begin
                errors++;
                $display("FAIL restart_word%0d: got ctl=%b word=%h expected ctl=%b word=%h", i, ctl, bus.wr_word, exp, fmt(w));
            end
        end
        bus.in_valid = 1'b0;
        tick;
        checks++;
        if (ctl !== 8'b0_0_011_010) begin
            errors++;
            $display("FAIL restart_done: got %b expected 00011010", ctl);
        end
    endtask

    task automatic test_bswap;
        logic [31:0] exp_w;
`ifdef AES_KEY_LOADER_BSWAP_EN
        exp_w = 32'h44332211;
`else
        exp_w = 32'h11223344;
`endif
        start_i = 1'b1; key_len_i = 2'b00;
        tick;
        start_i = 1'b0;
        bus.in_valid = 1'b1; bus.in_word = 32'h11223344;
        tick;
        checks++;
        if (bus.wr_word !== exp_w || bus.wr_en !== 1'b1) begin
            errors++;
            $display("FAIL bswap_word: got en=%b word=%h expected en=1 word=%h", bus.wr_en, bus.wr_word, exp_w);
        end
        for (int i = 1; i < 4; i++) begin
            bus.in_word = 32'h55667788;
            tick;
        end
        bus.in_valid = 1'b0;
        tick;
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL bswap_done: got done=%b err=%b expected done=1 err=0", done_o, err_o);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_word  = '0;
        test_reset;
        test_aes128;
        test_aes256_gaps;
        test_reserved;
        test_midload;
        test_bswap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
